ntt_stage_ctrl: RTL and testbench

Sequencer for an in-place Cooley-Tukey forward NTT over Z_7681 (N = 256 by default). Drives a coefficient RAM and a twiddle ROM (both synchronous-read, one-cycle latency), feeds their outputs to the registered butterfly unit's a/b/shi inputs, and writes the unit's B1/B2 results back to the same addresses. Sits directly upstream of the butterfly unit and owns loop order, the address pipeline and the read-after-write drain between stages.

---
 rtl/ntt_stage_ctrl.sv | 146 ++++++++++++++
 tb/tb_ntt_stage_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_stage_ctrl.sv
// Address sequencer for an in-place Cooley-Tukey NTT: walks the len/block/j loops,
// issues one butterfly per cycle and replays each address pair two cycles later as a write.
module ntt_stage_ctrl #(
  parameter int LOGN = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-1:0] tw_idx,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b
);

  localparam logic [LOGN-1:0] ONE  = {{(LOGN-1){1'b0}}, 1'b1};
  localparam logic [LOGN-1:0] HALF = {1'b1, {(LOGN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state;
  logic [LOGN-1:0] len, base, off, k, cnt;
  logic            drain_cnt;
  logic [LOGN-1:0] nxt_j, nxt_base, nxt_off, nxt_k;
  logic            blk_end;
  logic            v1;
  logic [LOGN-1:0] a1, b1;

  // Next issue position: step j inside the block, or jump to the next block with a new twiddle.
  always_comb begin
    blk_end  = (off == len - ONE);
    nxt_base = base;
    nxt_off  = off + ONE;
    nxt_k    = k;
    if (blk_end) begin
      nxt_base = base + (len << 1);
      nxt_off  = '0;
      nxt_k    = k + ONE;
    end
    nxt_j = nxt_base + nxt_off;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_idx    <= '0;
      len       <= '0;
      base      <= '0;
      off       <= '0;
      k         <= '0;
      cnt       <= '0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            rd_en     <= 1'b1;
            rd_addr_a <= '0;
            rd_addr_b <= HALF;
            tw_idx    <= ONE;
            len       <= HALF;
            base      <= '0;
            off       <= '0;
            k         <= ONE;
            cnt       <= ONE;
          end
        end
        // cnt counts issues already on the bus in this stage; N/2 of them end the stage.
        RUN: begin
          if (cnt == HALF) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_idx    <= '0;
          end else begin
            base      <= nxt_base;
            off       <= nxt_off;
            k         <= nxt_k;
            cnt       <= cnt + ONE;
            rd_addr_a <= nxt_j;
            rd_addr_b <= nxt_j + len;
            tw_idx    <= nxt_k;
          end
        end
        DRAIN: begin
          if (!drain_cnt) begin
            drain_cnt <= 1'b1;
          end else if (len == ONE) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= RUN;
            rd_en     <= 1'b1;
            len       <= len >> 1;
            base      <= '0;
            off       <= '0;
            k         <= k + ONE;
            cnt       <= ONE;
            rd_addr_a <= '0;
            rd_addr_b <= len >> 1;
            tw_idx    <= k + ONE;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Addresses are already zero whenever rd_en is low, so they pass through unqualified.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      a1        <= '0;
      b1        <= '0;
      wr_en     <= 1'b0;
      wr_addr_a <= '0;
      wr_addr_b <= '0;
    end else begin
      v1        <= rd_en;
      a1        <= rd_addr_a;
      b1        <= rd_addr_b;
      wr_en     <= v1;
      wr_addr_a <= a1;
      wr_addr_b <= b1;
    end
  end

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Self-checking bench for ntt_stage_ctrl: scoreboarded N=256 traces with a RAM/butterfly
// model, a cycle table for N=4, and start/reset corner cases.
module tb_ntt_stage_ctrl;

  localparam int LOGN    = 8;
  localparam int N       = 1 << LOGN;
  localparam int HALF    = N / 2;
  localparam int RUN_LEN = LOGN * (HALF + 2);
  localparam int Q       = 7681;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, start, busy, done, rd_en, wr_en;
  logic [LOGN-1:0] rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b;

  logic       rst_s, start_s, busy_s, done_s, rd_en_s, wr_en_s;
  logic [1:0] rd_addr_a_s, rd_addr_b_s, tw_idx_s, wr_addr_a_s, wr_addr_b_s;

  ntt_stage_ctrl #(.LOGN(LOGN)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  ntt_stage_ctrl #(.LOGN(2)) dut_small (
    .clk(clk), .rst(rst_s), .start(start_s), .busy(busy_s), .done(done_s),
    .rd_en(rd_en_s), .rd_addr_a(rd_addr_a_s), .rd_addr_b(rd_addr_b_s), .tw_idx(tw_idx_s),
    .wr_en(wr_en_s), .wr_addr_a(wr_addr_a_s), .wr_addr_b(wr_addr_b_s)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int cyc;
    int a;
    int b;
    int k;
  } issue_t;

  typedef struct packed {
    logic       rd_en;
    logic [1:0] a, b, k;
    logic       wr_en;
    logic [1:0] wa, wb;
    logic       busy, done;
  } vec_t;

  typedef struct {
    string name;
    int    off;
    int    a, b, k;
  } point_t;

  issue_t rd_q[$];
  issue_t wr_q[$];
  bit     mon_on = 1'b0;
  bit     active = 1'b0;
  int     exp_start = 0;
  int     wr_cnt = 0;
  vec_t   vt[10];
  point_t pts[5];

  // Coefficient RAM, twiddle ROM and a registered butterfly with the documented latencies.
  int   mem[N];
  logic init_req = 1'b0;
  int   ra = 0, rb = 0, tw = 0, bu1 = 0, bu2 = 0;

  always @(posedge clk) begin
    if (init_req)
      for (int i = 0; i < N; i++) mem[i] <= (i == 0) ? 1 : 0;
    if (rd_en) begin
      ra <= mem[rd_addr_a];
      rb <= mem[rd_addr_b];
      tw <= (int'(tw_idx) * 3 + 1) % Q;
    end
    bu1 <= (ra + tw * rb) % Q;
    bu2 <= (ra + Q - (tw * rb) % Q) % Q;
    if (wr_en) begin
      mem[wr_addr_a] <= bu1;
      mem[wr_addr_b] <= bu2;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] packIssue(input integer c, input integer a, input integer b,
                                            input integer k);
    return {8'h00, c[31:0], a[7:0], b[7:0], k[7:0]};
  endfunction

  function automatic vec_t mkVec(input int re, input int a, input int b, input int k,
                                 input int we, input int wa, input int wb, input int bz,
                                 input int dn);
    vec_t v;
    v.rd_en = re[0];
    v.a     = a[1:0];
    v.b     = b[1:0];
    v.k     = k[1:0];
    v.wr_en = we[0];
    v.wa    = wa[1:0];
    v.wb    = wb[1:0];
    v.busy  = bz[0];
    v.done  = dn[0];
    return v;
  endfunction

  task automatic waitCycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sampleAt(input int c);
    waitCycle(c);
    @(negedge clk);
  endtask

  // Reference loop nest: every issue and its write-back, timed from the start cycle s0.
  task automatic planRun(input int s0);
    int t = s0 + 1;
    int k = 1;
    for (int len = HALF; len >= 1; len = len / 2) begin
      for (int base = 0; base < N; base += 2 * len) begin
        for (int j = base; j < base + len; j++) begin
          rd_q.push_back('{t, j, j + len, k});
          wr_q.push_back('{t + 2, j, j + len, k});
          t++;
        end
        k++;
      end
      t += 2;
    end
    exp_start = s0;
    active    = 1'b1;
    wr_cnt    = 0;
  endtask

  task automatic applyStimulus(input int c);
    waitCycle(c);
    start = 1'b1;
    waitCycle(c + 1);
    start = 1'b0;
  endtask

  task automatic checkImpulse(input string name);
    int bad = 0;
    for (int i = 0; i < N; i++)
      if (mem[i] != 1) bad++;
    checkOutput({name, "_bad_coeffs"}, 64'(bad), 64'd0);
    checkOutput({name, "_wr_count"}, 64'(wr_cnt), 64'(LOGN * HALF));
    checkOutput({name, "_rd_left"}, 64'(rd_q.size()), 64'd0);
    checkOutput({name, "_wr_left"}, 64'(wr_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    issue_t e;
    bit     be, de;
    if (mon_on) begin
      if (rd_en) begin
        if (rd_q.size() == 0) checkOutput("rd_unexpected", 64'd1, 64'd0);
        else begin
          e = rd_q.pop_front();
          checkOutput("rd_issue", packIssue(cyc, rd_addr_a, rd_addr_b, tw_idx),
                      packIssue(e.cyc, e.a, e.b, e.k));
        end
      end else begin
        checkOutput("rd_idle_zero", 64'({rd_addr_a, rd_addr_b, tw_idx}), 64'd0);
        if (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
          e = rd_q.pop_front();
          checkOutput("rd_missing", 64'd0, 64'd1);
        end
      end
      if (wr_en) begin
        wr_cnt++;
        if (wr_q.size() == 0) checkOutput("wr_unexpected", 64'd1, 64'd0);
        else begin
          e = wr_q.pop_front();
          checkOutput("wr_issue", packIssue(cyc, wr_addr_a, wr_addr_b, 0),
                      packIssue(e.cyc, e.a, e.b, 0));
        end
      end else begin
        checkOutput("wr_idle_zero", 64'({wr_addr_a, wr_addr_b}), 64'd0);
        if (wr_q.size() != 0 && wr_q[0].cyc <= cyc) begin
          e = wr_q.pop_front();
          checkOutput("wr_missing", 64'd0, 64'd1);
        end
      end
      be = active && cyc >= exp_start + 1 && cyc <= exp_start + RUN_LEN;
      de = active && cyc == exp_start + RUN_LEN + 1;
      checkOutput("busy_done", 64'({busy, done}), 64'({be, de}));
    end
  end

  initial begin
    int sa, sb, sc;

    vt[0] = mkVec(1, 0, 2, 1, 0, 0, 0, 1, 0);
    vt[1] = mkVec(1, 1, 3, 1, 0, 0, 0, 1, 0);
    vt[2] = mkVec(0, 0, 0, 0, 1, 0, 2, 1, 0);
    vt[3] = mkVec(0, 0, 0, 0, 1, 1, 3, 1, 0);
    vt[4] = mkVec(1, 0, 1, 2, 0, 0, 0, 1, 0);
    vt[5] = mkVec(1, 2, 3, 3, 0, 0, 0, 1, 0);
    vt[6] = mkVec(0, 0, 0, 0, 1, 0, 1, 1, 0);
    vt[7] = mkVec(0, 0, 0, 0, 1, 2, 3, 1, 0);
    vt[8] = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1);
    vt[9] = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0);

    pts[0] = '{"s0_issue1",   1,    0,   128, 1};
    pts[1] = '{"s0_issue128", 128,  127, 255, 1};
    pts[2] = '{"s1_issue1",   131,  0,   64,  2};
    pts[3] = '{"s1_issue65",  195,  128, 192, 3};
    pts[4] = '{"final_issue", 1038, 254, 255, 255};

    rst = 1'b1; start = 1'b0; rst_s = 1'b1; start_s = 1'b0;
    sampleAt(2);
    checkOutput("reset_state",
                64'({busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx, wr_en, wr_addr_a, wr_addr_b}),
                64'd0);
    waitCycle(3);
    rst = 1'b0; rst_s = 1'b0;
    waitCycle(4);
    mon_on = 1'b1;

    waitCycle(6);
    start_s = 1'b1;
    waitCycle(7);
    start_s = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sampleAt(7 + i);
      checkOutput($sformatf("n4_cycle%0d", i + 1),
                  64'({rd_en_s, rd_addr_a_s, rd_addr_b_s, tw_idx_s, wr_en_s, wr_addr_a_s,
                       wr_addr_b_s, busy_s, done_s}), 64'(vt[i]));
    end

    waitCycle(20);
    init_req = 1'b1;
    waitCycle(21);
    init_req = 1'b0;
    sa = 24;
    waitCycle(sa);
    planRun(sa);
    start = 1'b1;
    waitCycle(sa + 1);
    start = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          sampleAt(sa + pts[i].off);
          checkOutput(pts[i].name, packIssue(rd_en, rd_addr_a, rd_addr_b, tw_idx),
                      packIssue(1, pts[i].a, pts[i].b, pts[i].k));
        end
      end
      begin
        applyStimulus(sa + 50);
        applyStimulus(sa + 129);
        applyStimulus(sa + RUN_LEN + 1);
      end
    join
    waitCycle(sa + RUN_LEN + 2);
    checkImpulse("run_a");

    sb = sa + RUN_LEN + 2;
    planRun(sb);
    start = 1'b1;
    waitCycle(sb + 1);
    start = 1'b0;
    waitCycle(sb + 500);
    rst = 1'b1;
    waitCycle(sb + 501);
    rst    = 1'b0;
    active = 1'b0;
    rd_q.delete();
    wr_q.delete();
    wr_cnt = 0;
    @(negedge clk);
    checkOutput("after_reset",
                64'({busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx, wr_en, wr_addr_a, wr_addr_b}),
                64'd0);
    waitCycle(sb + 520);
    checkOutput("no_wr_after_reset", 64'(wr_cnt), 64'd0);
    init_req = 1'b1;
    waitCycle(sb + 521);
    init_req = 1'b0;

    sc = sb + 524;
    waitCycle(sc);
    planRun(sc);
    start = 1'b1;
    waitCycle(sc + 1);
    start = 1'b0;
    waitCycle(sc + RUN_LEN + 3);
    checkImpulse("run_c");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
